fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter: RESET_PC, 32'h0000_0040, first fetch address after reset.
REQ-002 SHALL have parameter: DEPTH, 2, instruction buffer entries; also the maximum number of outstanding plus buffered fetches.
REQ-003 SHALL have port: clk  in  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port: reset_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port: imem_req  out  1  fetch request valid.
REQ-006 SHALL have port: imem_addr  out  32  word-aligned fetch address.
REQ-007 SHALL have port: imem_ack  in  1  memory accepts the request this cycle.
REQ-008 SHALL have port: imem_rvalid  in  1  read data valid; responses return in request order.
REQ-009 SHALL have port: imem_rdata  in  32  instruction word.
REQ-010 SHALL have port: pcOut  out  32  PC of the instruction presented to decode.
REQ-011 SHALL have port: instWord  out  32  instruction presented to decode.
REQ-012 SHALL have port: inst_valid  out  1  pcOut/instWord valid.
REQ-013 SHALL have port: stall  in  1  decode cannot accept this cycle.
REQ-014 SHALL have port: enBranch  in  1  redirect from the controller.
REQ-015 SHALL have port: pcNext  in  32  redirect target from the controller.

Function
REQ-016 SHALL assert imem_req combinationally when reset_n=1, enBranch=0 and outstanding+buffered < DEPTH; imem_addr = fetch_pc.
REQ-017 SHALL count a request handshake on imem_req && imem_ack; on a handshake, fetch_pc += 4 (mod 2^32) and outstanding += 1.
REQ-018 SHALL wrap fetch_pc from 32'hFFFF_FFFC to 32'h0000_0000 without error.
REQ-019 SHALL, on imem_rvalid with drop_cnt > 0, discard the data and decrement drop_cnt.
REQ-020 SHALL, on imem_rvalid with drop_cnt = 0, push {resp_pc, imem_rdata} into the buffer, set resp_pc += 4 and decrement outstanding.
REQ-021 SHALL ignore imem_rvalid when outstanding = 0, leaving all counters unchanged.
REQ-022 SHALL drive inst_valid = buffer non-empty, with pcOut/instWord = buffer head (registered; one cycle after the push).
REQ-023 SHALL drive instWord = 0 (NOP) while inst_valid=0, and SHALL hold pcOut at its last value.
REQ-024 SHALL pop the head when inst_valid && !stall.
REQ-025 SHALL allow a push and a pop in the same cycle; the credit rule in REQ-016 guarantees the buffer never overflows.
REQ-026 SHALL give enBranch priority over all other events; in the enBranch cycle:
  - the buffer is cleared, with no pop counted;
  - drop_cnt is loaded with the in-flight responses (outstanding, minus 1 if imem_rvalid is high, that response being dropped);
  - outstanding becomes 0;
  - fetch_pc and resp_pc are loaded with {pcNext[31:2], 2'b00};
  - no request is issued.
REQ-027 SHALL force pcNext[1:0] to zero on redirect.
REQ-028 SHALL accept a new enBranch while drop_cnt > 0, accumulating the still-pending responses into drop_cnt.
REQ-029 SHALL achieve a best-case latency, with an always-acked memory and 1-cycle read latency, of: request in cycle N, rvalid in N+1, inst_valid in N+2.

Reset
REQ-030 SHALL, while reset_n=0, immediately set: fetch_pc = resp_pc = RESET_PC; outstanding = drop_cnt = 0; buffer empty; inst_valid = 0; instWord = 0; pcOut = RESET_PC; imem_req = 0.
REQ-031 SHALL treat requests in flight when reset asserts as lost; the memory is reset concurrently and returns no stale data.
REQ-032 SHALL issue the first request (address RESET_PC) in the first cycle after reset_n rises.

Configuration
REQ-033 SHALL, with macro FETCH_PERF_CNT_EN defined, add output flush_cnt (16-bit) counting enBranch cycles and output stall_cnt (16-bit) counting inst_valid && stall cycles; both counters saturate at 16'hFFFF and reset to 0.
REQ-034 SHALL, without FETCH_PERF_CNT_EN, omit both ports and counters; all other behaviour is identical.

Verification
REQ-035 SHALL cover: reset release, ack=1, rdata=addr -> imem_addr 0x40, 0x44, 0x48...; inst_valid from cycle 2; pcOut/instWord 0x40/0x40, then 0x44/0x44.
REQ-036 SHALL cover: stall=1 held 5 cycles with a streaming memory -> at most 2 requests in flight plus buffered; no loss; on release, order is 0x40, 0x44 with no duplicates.
REQ-037 SHALL cover: enBranch with pcNext=0x103 while 2 requests are outstanding -> both responses dropped; next imem_addr = 0x100; next valid pcOut = 0x100.
REQ-038 SHALL cover: RESET_PC = 32'hFFFF_FFF8 -> fetch addresses FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-039 SHALL cover: reset_n pulsed low mid-stream with 1 outstanding -> inst_valid = 0 immediately; after release, the first request is 0x40.
REQ-040 SHALL cover: with FETCH_PERF_CNT_EN, 3 redirects and 4 stalled-valid cycles -> flush_cnt = 3, stall_cnt = 4.

Source files
------------

// File: rtl/fetch_unit.sv
`timescale 1ns/1ps
// fetch_unit: instruction fetch front end.
//
// Issues word-aligned fetches to instruction memory and tracks credits so that
// in-flight plus buffered fetches never exceed DEPTH. In-order responses land
// in a small FIFO whose head is presented to decode. A redirect from the
// controller (enBranch) flushes the FIFO, restarts fetch at {pcNext[31:2],2'b00},
// and counts in-flight responses that must be dropped on return.
//
// Parameters
//   RESET_PC  first fetch address after reset
//   DEPTH     FIFO entries; also the cap on outstanding + buffered fetches
//
// Ports
//   clk, reset_n              clock, asynchronous active-low reset
//   imem_req/imem_addr        fetch request (combinational) and its address
//   imem_ack                  memory accepts the request this cycle
//   imem_rvalid/imem_rdata    in-order read response
//   pcOut/instWord/inst_valid registered FIFO head presented to decode
//   stall                     decode cannot accept this cycle
//   enBranch/pcNext           redirect from the controller
//
// Optional build macro FETCH_PERF_CNT_EN adds:
//   flush_cnt  saturating count of enBranch cycles
//   stall_cnt  saturating count of inst_valid && stall cycles
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0040,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pcOut,
    output logic [31:0] instWord,
    output logic        inst_valid,
    input  logic        stall,
    input  logic        enBranch,
    input  logic [31:0] pcNext
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0] flush_cnt,
    output logic [15:0] stall_cnt
`endif
);

    // Counter widths: CW holds 0..DEPTH, SW holds the credit sum, DW leaves
    // headroom for drop counts that accumulate across back-to-back redirects.
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned SW = CW + 1;
    localparam int unsigned DW = CW + 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } entry_t;

    entry_t        r_buf [DEPTH];
    entry_t        w_buf_nxt [DEPTH];
    logic [CW-1:0] r_count;
    logic [CW-1:0] w_count_nxt;
    logic [CW-1:0] r_outst;
    logic [CW-1:0] w_outst_nxt;
    logic [DW-1:0] r_drop;
    logic [DW-1:0] w_drop_nxt;
    logic [31:0]   r_fetch_pc;
    logic [31:0]   w_fetch_pc_nxt;
    logic [31:0]   r_resp_pc;
    logic [31:0]   w_resp_pc_nxt;
    logic          r_inst_valid;
    logic [31:0]   r_pc_out;
    logic [31:0]   r_inst_word;

    logic          w_credit;
    logic          w_hs;
    logic          w_accept;
    logic          w_drop_rsp;
    logic          w_pop;
    logic [CW-1:0] w_tail;
    logic [DW-1:0] w_pending;
    logic [31:0]   w_redirect_pc;
    logic          w_unused_pc_lsb;

    // Credit: never allow more fetches in flight plus buffered than FIFO slots.
    assign w_credit  = (SW'(r_outst) + SW'(r_count)) < SW'(DEPTH);
    assign imem_req  = reset_n && !enBranch && w_credit;
    assign imem_addr = r_fetch_pc;
    assign w_hs      = imem_req && imem_ack;

    // Responses retire pending drops first; with nothing in flight they are ignored.
    assign w_drop_rsp = imem_rvalid && (r_drop != '0);
    assign w_accept   = imem_rvalid && (r_drop == '0) && (r_outst != '0);
    assign w_pop      = (r_count != '0) && !stall;
    assign w_tail     = r_count - CW'(w_pop);

    // Everything still to return from memory at a redirect becomes a drop.
    assign w_pending     = r_drop + DW'(r_outst);
    assign w_redirect_pc = {pcNext[31:2], 2'b00};
    assign w_unused_pc_lsb = ^pcNext[1:0];

    // Next-state for pointers, counters and FIFO contents.
    always_comb begin
        w_buf_nxt      = r_buf;
        w_count_nxt    = r_count;
        w_outst_nxt    = r_outst;
        w_drop_nxt     = r_drop;
        w_fetch_pc_nxt = r_fetch_pc;
        w_resp_pc_nxt  = r_resp_pc;

        if (enBranch) begin
            w_count_nxt    = '0;
            w_outst_nxt    = '0;
            w_drop_nxt     = (imem_rvalid && (w_pending != '0)) ? (w_pending - DW'(1)) : w_pending;
            w_fetch_pc_nxt = w_redirect_pc;
            w_resp_pc_nxt  = w_redirect_pc;
        end else begin
            if (w_hs) begin
                w_fetch_pc_nxt = r_fetch_pc + 32'd4;
            end
            w_outst_nxt = r_outst + CW'(w_hs) - CW'(w_accept);
            if (w_drop_rsp) begin
                w_drop_nxt = r_drop - DW'(1);
            end

            // Pop shifts the FIFO toward slot 0 so the head is always entry 0.
            if (w_pop) begin
                for (int i = 0; i < int'(DEPTH) - 1; i++) begin
                    w_buf_nxt[i] = r_buf[i+1];
                end
            end
            w_count_nxt = w_tail;

            if (w_accept) begin
                for (int i = 0; i < int'(DEPTH); i++) begin
                    if (CW'(i) == w_tail) begin
                        w_buf_nxt[i] = {r_resp_pc, imem_rdata};
                    end
                end
                w_resp_pc_nxt = r_resp_pc + 32'd4;
                w_count_nxt   = w_tail + CW'(1);
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_buf[i] <= '0;
            end
            r_count    <= '0;
            r_outst    <= '0;
            r_drop     <= '0;
            r_fetch_pc <= RESET_PC;
            r_resp_pc  <= RESET_PC;
        end else begin
            r_buf      <= w_buf_nxt;
            r_count    <= w_count_nxt;
            r_outst    <= w_outst_nxt;
            r_drop     <= w_drop_nxt;
            r_fetch_pc <= w_fetch_pc_nxt;
            r_resp_pc  <= w_resp_pc_nxt;
        end
    end

    // Decode-facing registers: NOP while empty, pcOut holds its last value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_inst_valid <= 1'b0;
            r_pc_out     <= RESET_PC;
            r_inst_word  <= '0;
        end else begin
            r_inst_valid <= (w_count_nxt != '0);
            if (w_count_nxt != '0) begin
                r_pc_out    <= w_buf_nxt[0].pc;
                r_inst_word <= w_buf_nxt[0].inst;
            end else begin
                r_inst_word <= '0;
            end
        end
    end

    assign inst_valid = r_inst_valid;
    assign pcOut      = r_pc_out;
    assign instWord   = r_inst_word;

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] r_flush_cnt;
    logic [15:0] r_stall_cnt;

    // Saturating performance counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_flush_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (enBranch && (r_flush_cnt != 16'hFFFF)) begin
                r_flush_cnt <= r_flush_cnt + 16'd1;
            end
            if (r_inst_valid && stall && (r_stall_cnt != 16'hFFFF)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
        end
    end

    assign flush_cnt = r_flush_cnt;
    assign stall_cnt = r_stall_cnt;
`endif

endmodule
